sp1_prog_mem: RTL and testbench
===============================

Name: sp1_prog_mem

Overview:
- Program memory and loader stage directly upstream of the sp1 processor.
- Holds 11-bit instruction words: data/address field in bits [10:3], opcode in bits [2:0].
- Returns the word addressed by the processor's pc and accepts data-field writebacks from the processor's store path.
- Contains a byte-serial loader FSM that fills memory from address 0 while holding the processor stalled via busy.

Parameters:
- DATA_W, 8, width of the data field and of loader bytes.
- OP_W, 3, opcode field width.
- ADDR_W, 8, pc width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_W  fetch address from processor.
- instr  out  DATA_W+OP_W  registered instruction word.
- wb_strobe  in  1  level from processor state[2]; rising edge requests writeback.
- wb_data  in  DATA_W  writeback value (processor out).
- ld_start  in  1  one-cycle pulse to begin a program load.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted when valid & ready.
- ld_byte  in  DATA_W  loader byte.
- ld_last  in  1  qualifies the opcode byte of the final word.
- busy  out  1  load in progress; processor must stall.
- ld_count  out  ADDR_W+1  words written by the current/last load.
- ld_err  out  1  sticky: opcode byte had nonzero bits above OP_W.
- ld_ovf  out  1  sticky: load reached the last address without ld_last.

Behaviour:
- Reset (async assert, sync-released use): FSM=IDLE, instr=0, ld_ready=0, busy=0, ld_count=0, ld_err=0, ld_ovf=0, write address=0, wb edge register=0. Memory contents are not reset.
- FSM states: IDLE, LD_HI, LD_LO.
- IDLE:
  - ld_ready=0, busy=0.
  - ld_start -> LD_HI; write address=0, ld_count=0, ld_err and ld_ovf cleared.
- LD_HI:
  - ld_ready=1, busy=1.
  - On accept, latch ld_byte as data field -> LD_LO.
  - ld_last is ignored in this state.
- LD_LO:
  - ld_ready=1, busy=1.
  - On accept, write {latched data, ld_byte[OP_W-1:0]} to mem[write address] and increment ld_count.
  - If ld_byte[DATA_W-1:OP_W] != 0, set ld_err; the word is still written.
  - After the write:
    - ld_last=1 -> IDLE.
    - Otherwise, if write address == 2**ADDR_W-1 -> set ld_ovf, go IDLE; address does not wrap.
    - Otherwise increment write address -> LD_HI.
- ld_valid low in a load state: hold state; there is no timeout.
- ld_start while busy is ignored.
- Fetch:
  - Every cycle, instr <= mem[pc]; latency is 1 cycle.
  - While busy, instr <= 0 (NOP) regardless of pc.
- Writeback:
  - Edge detect on registered wb_strobe. On a 0->1 transition with busy=0, mem[pc][10:3] <= wb_data; the opcode bits are unchanged.
  - A rise while busy is dropped and is not deferred.
- Same-cycle writeback and fetch of the same pc: instr returns the old word (read-before-write); the new word appears on the following cycle.
- Loader write and writeback cannot collide, because writeback is disabled while busy.
- Reset mid-load: FSM returns to IDLE immediately; words already written are kept; flags and count are cleared.

Test Plan:
- Load words ($05,op1), ($66,op4), ($10,op0 with ld_last): ld_count=3, busy falls after the third LD_LO accept. Then pc=1 -> next-cycle instr=11'h334, and pc=0 -> instr=11'h029.
- Backpressure: drop ld_valid for 5 cycles between the hi and lo bytes -> FSM holds LD_LO, ld_ready stays 1, and the word is written only on the eventual accept.
- Opcode byte $F9 -> word opcode=3'b001 written, ld_err=1 and stays set until the next ld_start.
- Stream 256 words with no ld_last -> ld_count=256, ld_ovf=1, FSM=IDLE, mem[255] written, mem[0] not overwritten.
- Writeback: pc=1 holding 11'h334, wb_data=$AB, raise wb_strobe -> instr for pc=1 = 11'h55C (opcode 4 kept). Holding wb_strobe high causes no second write. A rise during busy leaves memory unchanged.
- Assert rst_n=0 after 2 words of a load -> busy=0, ld_count=0, instr=0 immediately, and the words at pc=0 and pc=1 remain readable after reset.

Source files
------------

// File: rtl/sp1_prog_mem.sv
// sp1_prog_mem: program memory for the sp1 processor.
// Holds 11-bit instruction words {data[7:0], opcode[2:0]}, serves fetches at
// pc with one cycle of latency, accepts data-field writebacks from the store
// path, and contains a byte-serial loader that fills memory from address 0
// while stalling the processor through busy.
module sp1_prog_mem #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   pc,
    output logic [DATA_W+OP_W-1:0] instr,
    input  logic                wb_strobe,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                ld_start,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [DATA_W-1:0]   ld_byte,
    input  logic                ld_last,
    output logic                busy,
    output logic [ADDR_W:0]     ld_count,
    output logic                ld_err,
    output logic                ld_ovf
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LD_HI = 2'd1,
        LD_LO = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   waddr_reg, waddr_next;
    logic [DATA_W-1:0]   hi_reg, hi_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic                err_reg, err_next;
    logic                ovf_reg, ovf_next;
    logic                wb_prev_reg;

    logic                accept;
    logic                ld_we;
    logic                wb_we;

    // Data field and opcode field live in separate arrays so a writeback can
    // replace the data field without a read-modify-write of the opcode.
    logic                data_we;
    logic [ADDR_W-1:0]   data_waddr;
    logic [DATA_W-1:0]   data_wdata;
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [OP_W-1:0]     op_mem   [DEPTH];

    // Loader state and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            waddr_reg <= '0;
            hi_reg    <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            waddr_reg <= waddr_next;
            hi_reg    <= hi_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Loader next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        waddr_next = waddr_reg;
        hi_next    = hi_reg;
        count_next = count_reg;
        err_next   = err_reg;
        ovf_next   = ovf_reg;
        ld_we      = 1'b0;
        ld_ready   = (state_reg != IDLE);
        busy       = (state_reg != IDLE);
        accept     = ld_valid && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (ld_start) begin
                    state_next = LD_HI;
                    waddr_next = '0;
                    count_next = '0;
                    err_next   = 1'b0;
                    ovf_next   = 1'b0;
                end
            end
            LD_HI: begin
                // ld_last only qualifies the opcode byte, so it is ignored here.
                if (accept) begin
                    hi_next    = ld_byte;
                    state_next = LD_LO;
                end
            end
            LD_LO: begin
                if (accept) begin
                    ld_we      = 1'b1;
                    count_next = count_reg + 1'b1;
                    if (|ld_byte[DATA_W-1:OP_W]) begin
                        err_next = 1'b1;
                    end
                    if (ld_last) begin
                        state_next = IDLE;
                    end else if (waddr_reg == {ADDR_W{1'b1}}) begin
                        // Top of memory reached without ld_last: stop, no wrap.
                        ovf_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        waddr_next = waddr_reg + 1'b1;
                        state_next = LD_HI;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Previous wb_strobe level, for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_prev_reg <= 1'b0;
        end else begin
            wb_prev_reg <= wb_strobe;
        end
    end

    // A rise while busy is simply dropped; it is not held for later.
    assign wb_we = wb_strobe && !wb_prev_reg && !busy;

    // Data-field write port: loader and writeback are exclusive through busy.
    always_comb begin
        data_we    = ld_we || wb_we;
        data_waddr = ld_we ? waddr_reg : pc;
        data_wdata = ld_we ? hi_reg    : wb_data;
    end

    // Memory array writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
        if (ld_we) begin
            op_mem[waddr_reg] <= ld_byte[OP_W-1:0];
        end
    end

    // Registered fetch; reads old contents on a same-cycle write, NOP while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
        end else if (busy) begin
            instr <= '0;
        end else begin
            instr <= {data_mem[pc], op_mem[pc]};
        end
    end

    assign ld_count = count_reg;
    assign ld_err   = err_reg;
    assign ld_ovf   = ovf_reg;

endmodule

// File: tb/tb_sp1_prog_mem.sv
// Directed testbench for sp1_prog_mem: loading, backpressure, error and
// overflow flags, fetch, writeback edge behaviour and reset during a load.
module tb_sp1_prog_mem;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc;
    logic [10:0] instr;
    logic        wb_strobe;
    logic [7:0]  wb_data;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        busy;
    logic [8:0]  ld_count;
    logic        ld_err;
    logic        ld_ovf;

    int total;
    int bad;

    sp1_prog_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .instr     (instr),
        .wb_strobe (wb_strobe),
        .wb_data   (wb_data),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .busy      (busy),
        .ld_count  (ld_count),
        .ld_err    (ld_err),
        .ld_ovf    (ld_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // Present one loader byte for a single cycle; ready must be high.
    task automatic send(input logic [7:0] b, input logic last);
        check("ld_ready_before_byte", ld_ready, 1);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [10:0] exp);
        pc = a;
        tick();
        check(tag, instr, exp);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        pc        = 8'd0;
        wb_strobe = 1'b0;
        wb_data   = 8'd0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_byte   = 8'd0;
        ld_last   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_instr", instr, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_count", ld_count, 0);
        check("rst_err", ld_err, 0);
        check("rst_ovf", ld_ovf, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", ld_ready, 0);

        // Load 1: ($05,op1) ($66,op4) ($10,op0,last)
        pulse_start();
        check("l1_busy", busy, 1);
        check("l1_ready", ld_ready, 1);
        send(8'h05, 1'b0);
        send(8'h01, 1'b0);
        check("l1_count1", ld_count, 1);
        send(8'h66, 1'b0);
        send(8'h04, 1'b0);
        send(8'h10, 1'b0);
        check("l1_busy_before_last", busy, 1);
        send(8'h00, 1'b1);
        check("l1_busy_done", busy, 0);
        check("l1_count", ld_count, 3);
        check("l1_err", ld_err, 0);
        check("l1_ovf", ld_ovf, 0);
        fetch("l1_pc1", 8'd1, 11'h334);
        fetch("l1_pc0", 8'd0, 11'h029);
        fetch("l1_pc2", 8'd2, 11'h080);

        // Writeback rise at pc=1: old word same cycle, new word next cycle
        pc        = 8'd1;
        wb_data   = 8'hAB;
        wb_strobe = 1'b1;
        tick();
        check("wb_read_before_write", instr, 11'h334);
        tick();
        check("wb_new_word", instr, 11'h55C);
        wb_data = 8'h11;
        tick();
        tick();
        check("wb_held_high_no_rewrite", instr, 11'h55C);
        wb_strobe = 1'b0;
        tick();

        // Load 2: ld_last on hi byte ignored, backpressure, bad opcode byte,
        // writeback rise while busy dropped, ld_start while busy ignored
        pc = 8'd2;
        pulse_start();
        send(8'h12, 1'b1);
        check("l2_last_on_hi_ignored", busy, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                wb_data   = 8'hEE;
                wb_strobe = 1'b1;
            end
            if (i == 3) wb_strobe = 1'b0;
            tick();
            check("bp_ready", ld_ready, 1);
            check("bp_busy", busy, 1);
            check("bp_count", ld_count, 0);
            check("bp_instr_nop", instr, 0);
        end
        send(8'hF9, 1'b0);
        check("l2_count1", ld_count, 1);
        check("l2_err_set", ld_err, 1);
        pulse_start();
        check("l2_start_ignored_err", ld_err, 1);
        check("l2_start_ignored_cnt", ld_count, 1);
        send(8'h20, 1'b0);
        send(8'h02, 1'b1);
        check("l2_done_busy", busy, 0);
        check("l2_count", ld_count, 2);
        check("l2_err_sticky", ld_err, 1);
        fetch("l2_pc2_wb_dropped", 8'd2, 11'h080);
        fetch("l2_pc0", 8'd0, 11'h091);
        fetch("l2_pc1", 8'd1, 11'h102);

        // Load 3: 256 words without ld_last -> overflow
        pulse_start();
        check("l3_err_cleared", ld_err, 0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = i[7:0];
            send(~iv, 1'b0);
            send({5'd0, iv[2:0]}, 1'b0);
        end
        check("ovf_count", ld_count, 256);
        check("ovf_flag", ld_ovf, 1);
        check("ovf_busy", busy, 0);
        check("ovf_ready", ld_ready, 0);
        ld_valid = 1'b1;
        ld_byte  = 8'h3C;
        tick();
        tick();
        ld_valid = 1'b0;
        check("ovf_count_after_extra", ld_count, 256);
        fetch("ovf_mem255", 8'd255, 11'h007);
        fetch("ovf_mem0_no_wrap", 8'd0, 11'h7F8);
        fetch("ovf_mem1", 8'd1, 11'h7F1);

        // Load 4: reset after two words
        pulse_start();
        check("l4_ovf_cleared", ld_ovf, 0);
        send(8'h33, 1'b0);
        send(8'h02, 1'b0);
        send(8'h44, 1'b0);
        send(8'h03, 1'b0);
        send(8'h55, 1'b0);
        check("l4_count_before_rst", ld_count, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", ld_count, 0);
        check("mid_rst_instr", instr, 0);
        check("mid_rst_ready", ld_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch("post_rst_pc0", 8'd0, 11'h19A);
        fetch("post_rst_pc1", 8'd1, 11'h223);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
